dmem_port_arbiter: RTL

- Shares one single-ported synchronous data memory between two requesters: the core load/store port (m0) and a debug/program-loader port (m1).
- m0 has priority. A starvation counter guarantees m1 a grant after MAX_WAIT consecutive denied cycles.
- m1 may lock the port for short bursts.
- Sits between single_cycle_core's MemWrite/ALUResult/WriteData/read_data and the data memory. Generates core_stall so the core holds its PC while denied.

---
 rtl/dmem_port_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: core (m0) has priority, loader (m1) gets a
// starvation-bounded slot and may lock the port for short bursts.
module dmem_port_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 4,
    parameter int MAX_LOCK = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    output logic          core_stall,
    input  logic          m1_req,
    input  logic          m1_lock,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(MAX_LOCK + 1);

    typedef enum logic {
        ARB,
        LOCKED
    } state_t;

    state_t        state;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic          rd_pend;
    logic          rd_owner;
    logic [DW-1:0] m0_rdata_q;
    logic [DW-1:0] m1_rdata_q;
    logic          wait_full;
    logic          lock_last;

    assign wait_full = (wait_cnt == WW'(MAX_WAIT));
    // lock_cnt counts burst grants already given; this grant is number lock_cnt+1
    assign lock_last = (lock_cnt == LW'(MAX_LOCK - 1));

    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (reset) begin
            if (state == LOCKED && m1_req) begin
                m1_gnt = 1'b1;
            end else if (state == ARB && m1_req && (!m0_req || wait_full)) begin
                m1_gnt = 1'b1;
            end else begin
                m0_gnt = m0_req;
            end
        end
    end

    always_comb begin
        mem_en    = m0_gnt | m1_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (m1_gnt) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end else if (m0_gnt) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
        end
    end

    assign core_stall = reset & m0_req & ~m0_gnt;

    assign m0_rvalid = reset & rd_pend & ~rd_owner;
    assign m1_rvalid = reset & rd_pend & rd_owner;
    assign m0_rdata  = m0_rvalid ? mem_rdata : m0_rdata_q;
    assign m1_rdata  = m1_rvalid ? mem_rdata : m1_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ARB;
            wait_cnt   <= '0;
            lock_cnt   <= '0;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            rd_pend  <= mem_en & ~mem_we;
            rd_owner <= m1_gnt;
            if (m0_rvalid) m0_rdata_q <= mem_rdata;
            if (m1_rvalid) m1_rdata_q <= mem_rdata;

            if (m1_req && !m1_gnt) begin
                wait_cnt <= wait_full ? wait_cnt : wait_cnt + WW'(1);
            end else begin
                wait_cnt <= '0;
            end

            unique case (state)
                ARB: begin
                    if (m1_gnt && m1_lock && MAX_LOCK > 1) begin
                        state    <= LOCKED;
                        lock_cnt <= LW'(1);
                    end
                end
                LOCKED: begin
                    if (!m1_gnt || !m1_lock || lock_last) begin
                        state    <= ARB;
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LW'(1);
                    end
                end
            endcase
        end
    end

endmodule
